// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle RV32I sequencer: FSM states, opcodes and error codes.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } mc_state_t;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OP     = 7'h33;
    localparam opcode_t OP_IMM = 7'h13;
    localparam opcode_t LOAD   = 7'h03;
    localparam opcode_t STORE  = 7'h23;
    localparam opcode_t BRANCH = 7'h63;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_ILLEGAL  = 2'd1,
        ERR_IMEM_TMO = 2'd2,
        ERR_DMEM_TMO = 2'd3
    } err_t;

    function automatic logic is_legal(input opcode_t op);
        return (op == OP) || (op == OP_IMM) || (op == LOAD) ||
               (op == STORE) || (op == BRANCH);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Datapath-facing bundle of the sequencer: memory handshakes, decode inputs, write enables.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    opcode_t opcode;
    logic    branch_taken;
    logic    imem_req;
    logic    imem_ready;
    logic    dmem_req;
    logic    dmem_we;
    logic    dmem_ready;
    logic    ir_wen;
    logic    mdr_wen;
    logic    reg_wen;
    logic    pc_wen;
    logic    pc_sel;

    modport master (
        input  opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_wen, mdr_wen, reg_wen, pc_wen, pc_sel
    );

    modport slave (
        output opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_wen, mdr_wen, reg_wen, pc_wen, pc_sel
    );

endinterface

// File: rtl/multicycle_ctrl_wrap_counter.sv
// Free-running wrap-around counter with synchronous clear and count enable.
module wrap_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (en) count_d = count_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (clear) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: steps FETCH/DECODE/EXEC/MEM/WB, gates datapath enables, times out stalled memory.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TMO_W   = 4,
    parameter int unsigned MEM_TMO = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    multicycle_ctrl_if.master   bus,
    output logic                halted,
    output logic [1:0]          err_code,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instret_cnt
);

    mc_state_t        state_q, state_d;
    err_t             err_q, err_d;
    logic [TMO_W-1:0] wait_q, wait_d;
    logic             last_wait;

    // Counter holds the ready=0 cycles already seen; the next miss would reach MEM_TMO.
    assign last_wait = (wait_q == TMO_W'(MEM_TMO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= ERR_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wait_d  = wait_q;
        case (state_q)
            IDLE:   if (start) state_d = FETCH;
            FETCH: begin
                if (bus.imem_ready) begin
                    state_d = DECODE;
                end else if (last_wait) begin
                    state_d = HALT;
                    err_d   = ERR_IMEM_TMO;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end
            DECODE: begin
                if (is_legal(bus.opcode)) begin
                    state_d = EXEC;
                end else begin
                    state_d = HALT;
                    err_d   = ERR_ILLEGAL;
                end
            end
            EXEC: begin
                case (bus.opcode)
                    OP, OP_IMM:  state_d = WB;
                    LOAD, STORE: state_d = MEM;
                    BRANCH:      state_d = FETCH;
                    default: begin
                        state_d = HALT;
                        err_d   = ERR_ILLEGAL;
                    end
                endcase
            end
            MEM: begin
                if (bus.dmem_ready) begin
                    state_d = (bus.opcode == STORE) ? FETCH : WB;
                end else if (last_wait) begin
                    state_d = HALT;
                    err_d   = ERR_DMEM_TMO;
                end else begin
                    wait_d = wait_q + TMO_W'(1);
                end
            end
            WB:     state_d = FETCH;
            HALT:   state_d = HALT;
            default: state_d = IDLE;
        endcase
        if ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEM))) wait_d = '0;
    end

    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.ir_wen   = 1'b0;
        bus.mdr_wen  = 1'b0;
        bus.reg_wen  = 1'b0;
        bus.pc_wen   = 1'b0;
        bus.pc_sel   = 1'b0;
        case (state_q)
            FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_wen   = bus.imem_ready;
            end
            EXEC: begin
                if (bus.opcode == BRANCH) begin
                    bus.pc_wen = 1'b1;
                    bus.pc_sel = bus.branch_taken;
                end
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (bus.opcode == STORE);
                if (bus.dmem_ready) begin
                    bus.pc_wen  = (bus.opcode == STORE);
                    bus.mdr_wen = (bus.opcode != STORE);
                end
            end
            WB: begin
                bus.reg_wen = 1'b1;
                bus.pc_wen  = 1'b1;
            end
            default: ;
        endcase
    end

    assign halted   = (state_q == HALT);
    assign err_code = err_q;

    wrap_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clear (rst),
        .en    ((state_q != IDLE) && (state_q != HALT)),
        .count (cycle_cnt)
    );

    wrap_counter #(.WIDTH(CNT_W)) u_instret_cnt (
        .clk   (clk),
        .clear (rst),
        .en    (bus.pc_wen),
        .count (instret_cnt)
    );

endmodule
